// File: rtl/rs_enc_lfsr.sv
// Streaming systematic RS(K+4,K) encoder over GF(2^8): message passthrough, then 4 LFSR parity bytes.
// Optional single-symbol error injector on the output, enabled by RS_ENC_ERRINJ_EN.
`timescale 1ns/1ps

module gf2m8_multi (
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  output logic [7:0] o_z_c
);
  logic [7:0] w_sh;
  logic [7:0] w_acc;

  // Shift-and-add product reduced by x^8+x^4+x^3+x^2+1
  always_comb begin
    w_sh  = i_x;
    w_acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i_y[i]) w_acc = w_acc ^ w_sh;
      w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? 8'h1d : 8'h00);
    end
    o_z_c = w_acc;
  end
endmodule

module rs_enc_lfsr #(
  parameter int unsigned K     = 251,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready,
`ifdef RS_ENC_ERRINJ_EN
  input  logic             err_ena,
  input  logic [CNT_W-1:0] err_idx,
  input  logic [7:0]       err_pat,
`endif
  output logic             enc_done
);
  localparam int unsigned SYM_W = 8;
  localparam int unsigned NPAR  = 4;

  typedef enum logic {ST_DATA = 1'b0, ST_PAR = 1'b1} state_t;

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [SYM_W-1:0] r_p0, r_p1, r_p2, r_p3;
  logic [SYM_W-1:0] w_p0_nx, w_p1_nx, w_p2_nx, w_p3_nx;
  logic [SYM_W-1:0] r_m_data, w_m_data_nx;
  logic             r_m_valid, w_m_valid_nx;
  logic             r_m_last, w_m_last_nx;
  logic             r_enc_done, w_enc_done_nx;
  logic             w_load_ok, w_s_ready, w_accept;
  logic [SYM_W-1:0] w_fb, w_fb_g3, w_fb_g2, w_fb_g1, w_fb_g0, w_inj;

  assign w_load_ok = ~r_m_valid | m_ready;
  assign w_s_ready = (r_state == ST_DATA) & w_load_ok;
  assign w_accept  = s_valid & w_s_ready;
  assign w_fb      = s_data ^ r_p3;

  // Feedback taps: g(x) = x^4 + 0x0f x^3 + 0x36 x^2 + 0x78 x + 0x40
  gf2m8_multi u_g3 (.i_x(w_fb), .i_y(8'h0f), .o_z_c(w_fb_g3));
  gf2m8_multi u_g2 (.i_x(w_fb), .i_y(8'h36), .o_z_c(w_fb_g2));
  gf2m8_multi u_g1 (.i_x(w_fb), .i_y(8'h78), .o_z_c(w_fb_g1));
  gf2m8_multi u_g0 (.i_x(w_fb), .i_y(8'h40), .o_z_c(w_fb_g0));

`ifdef RS_ENC_ERRINJ_EN
  logic             r_err_ena, w_first, w_ena_use;
  logic [CNT_W-1:0] r_err_idx, w_idx_use, w_pos;
  logic [SYM_W-1:0] r_err_pat, w_pat_use;

  // Settings are live on the first message byte, then held for the rest of the codeword
  assign w_first   = w_accept & (r_cnt == '0);
  assign w_ena_use = w_first ? err_ena : r_err_ena;
  assign w_idx_use = w_first ? err_idx : r_err_idx;
  assign w_pat_use = w_first ? err_pat : r_err_pat;
  assign w_pos     = (r_state == ST_DATA) ? r_cnt : r_cnt + CNT_W'(K);
  assign w_inj     = (w_ena_use && (w_pos == w_idx_use)) ? w_pat_use : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_ena <= 1'b0;
      r_err_idx <= '0;
      r_err_pat <= '0;
    end else if (w_first) begin
      r_err_ena <= err_ena;
      r_err_idx <= err_idx;
      r_err_pat <= err_pat;
    end
  end
`else
  assign w_inj = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_DATA;
      r_cnt      <= '0;
      r_p0       <= '0;
      r_p1       <= '0;
      r_p2       <= '0;
      r_p3       <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_enc_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_p0       <= w_p0_nx;
      r_p1       <= w_p1_nx;
      r_p2       <= w_p2_nx;
      r_p3       <= w_p3_nx;
      r_m_data   <= w_m_data_nx;
      r_m_valid  <= w_m_valid_nx;
      r_m_last   <= w_m_last_nx;
      r_enc_done <= w_enc_done_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_p0_nx       = r_p0;
    w_p1_nx       = r_p1;
    w_p2_nx       = r_p2;
    w_p3_nx       = r_p3;
    w_m_data_nx   = r_m_data;
    w_m_valid_nx  = r_m_valid & ~m_ready;
    w_m_last_nx   = r_m_last & ~m_ready;
    w_enc_done_nx = r_m_valid & m_ready & r_m_last;
    case (r_state)
      ST_DATA: begin
        if (w_accept) begin
          w_p3_nx      = r_p2 ^ w_fb_g3;
          w_p2_nx      = r_p1 ^ w_fb_g2;
          w_p1_nx      = r_p0 ^ w_fb_g1;
          w_p0_nx      = w_fb_g0;
          w_m_data_nx  = s_data ^ w_inj;
          w_m_valid_nx = 1'b1;
          w_m_last_nx  = 1'b0;
          if (r_cnt == CNT_W'(K - 1)) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_PAR;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_PAR: begin
        // Parity drains highest degree first by shifting the remainder register
        if (w_load_ok) begin
          w_m_data_nx  = r_p3 ^ w_inj;
          w_m_valid_nx = 1'b1;
          w_p3_nx      = r_p2;
          w_p2_nx      = r_p1;
          w_p1_nx      = r_p0;
          w_p0_nx      = '0;
          if (r_cnt == CNT_W'(NPAR - 1)) begin
            w_m_last_nx = 1'b1;
            w_cnt_nx    = '0;
            w_state_nx  = ST_DATA;
            w_p3_nx     = '0;
            w_p2_nx     = '0;
            w_p1_nx     = '0;
          end else begin
            w_m_last_nx = 1'b0;
            w_cnt_nx    = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nx = ST_DATA;
    endcase
  end

  assign s_ready  = w_s_ready;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_last   = r_m_last;
  assign enc_done = r_enc_done;
endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Scoreboard bench for rs_enc_lfsr: directed codewords with hand-computed parity, backpressure, reset.
`timescale 1ns/1ps

module tb_rs_enc_lfsr;
  localparam int unsigned K     = 251;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned N     = K + 4;

  typedef struct packed {
    logic       chk;
    logic [7:0] data;
    logic       last;
  } exp_t;
  typedef logic [7:0] msg_t [K];

  logic             clk, rstn;
  logic             s_valid, s_ready, m_valid, m_last, m_ready, enc_done;
  logic [7:0]       s_data, m_data;
`ifdef RS_ENC_ERRINJ_EN
  logic             err_ena;
  logic [CNT_W-1:0] err_idx;
  logic [7:0]       err_pat;
`endif

  rs_enc_lfsr #(.K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
`ifdef RS_ENC_ERRINJ_EN
    .err_ena(err_ena), .err_idx(err_idx), .err_pat(err_pat),
`endif
    .enc_done(enc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks, errors;
  exp_t       sb[$];
  logic [7:0] cw[$];
  bit         rnd_ready, skip_syn, prev_hold, exp_done;
  logic [8:0] prev_word;
  exp_t       mon_e;
  msg_t       z_msg, m1_msg, mx_msg, m2_msg, r_msg;
  int         st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1d : 8'h00);
    end
    return p;
  endfunction

  always @(posedge clk) if (rnd_ready) begin
    #1 m_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every output handshake, checks hold, enc_done, syndromes
  always @(negedge clk) begin
    if (!rstn) begin
      prev_hold = 1'b0;
      exp_done  = 1'b0;
      cw.delete();
    end else begin
      if (exp_done || enc_done) check("enc_done", 32'(enc_done), 32'(exp_done));
      exp_done = 1'b0;
      if (prev_hold) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'({m_last, m_data}), 32'(prev_word));
      end
      prev_hold = m_valid && !m_ready;
      prev_word = {m_last, m_data};
      if (m_valid && m_ready) begin
        cw.push_back(m_data);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got 0x%0h, expected no output at %0t", m_data, $time);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.chk) check("data", 32'(m_data), 32'(mon_e.data));
          check("last", 32'(m_last), 32'(mon_e.last));
        end
        if (m_last) begin
          check("cw_len", cw.size(), N);
          if (!skip_syn) begin
            for (int j = 0; j < 4; j++) begin
              logic [7:0] s;
              s = 8'h00;
              foreach (cw[i]) s = gf_mul(s, 8'(1 << j)) ^ cw[i];
              check($sformatf("syndrome%0d", j), 32'(s), 32'd0);
            end
          end
          cw.delete();
          exp_done = 1'b1;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input exp_t e, output int stalls);
    bit ok;
    ok     = 1'b0;
    stalls = 0;
    s_valid = 1'b1;
    s_data  = b;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      else if (m_ready) stalls++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_ready=0 for 1000 cycles, expected 1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input msg_t msg, input bit par_known, input logic [31:0] par,
                           input int e_idx, input logic [7:0] e_pat, output int first_stalls);
    exp_t e;
    int   s;
    first_stalls = 0;
    for (int i = 0; i < K; i++) begin
      e.chk  = 1'b1;
      e.last = 1'b0;
      e.data = msg[i] ^ ((i == e_idx) ? e_pat : 8'h00);
      send_byte(msg[i], e, s);
      if (i == 0) first_stalls = s;
    end
    for (int i = 0; i < 4; i++) begin
      e.chk  = par_known;
      e.last = (i == 3);
      e.data = par[31 - 8*i -: 8] ^ ((int'(K) + i == e_idx) ? e_pat : 8'h00);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && sb.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    rnd_ready = 1'b0; skip_syn = 1'b0;
`ifdef RS_ENC_ERRINJ_EN
    err_ena = 1'b0; err_idx = '0; err_pat = 8'h00;
`endif
    foreach (z_msg[i]) z_msg[i] = 8'h00;
    m1_msg = z_msg; m1_msg[K-1] = 8'h01;
    mx_msg = z_msg; mx_msg[K-2] = 8'h01;
    m2_msg = z_msg; m2_msg[K-1] = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_enc_done", 32'(enc_done), 32'd0);
    rstn = 1'b1;
    #1 check("rel_s_ready", 32'(s_ready), 32'd1);

    // Back-to-back directed codewords; 4 stall cycles between words means no bubble
    send_word(z_msg, 1'b1, 32'h00000000, -1, 8'h00, st);
    send_word(m1_msg, 1'b1, 32'h0f367840, -1, 8'h00, st);
    check("gap_m1", st, 4);
    send_word(mx_msg, 1'b1, 32'h6357d2e7, -1, 8'h00, st);
    check("gap_mx", st, 4);
    send_word(m2_msg, 1'b1, 32'h1e6cf080, -1, 8'h00, st);
    check("gap_m2", st, 4);
    for (int w = 0; w < 2; w++) begin
      foreach (r_msg[i]) r_msg[i] = 8'($urandom);
      send_word(r_msg, 1'b0, 32'h0, -1, 8'h00, st);
      check("gap_rnd", st, 4);
    end
    s_valid = 1'b0;
    drain();

    // Same vectors under random downstream backpressure
    rnd_ready = 1'b1;
    send_word(m1_msg, 1'b1, 32'h0f367840, -1, 8'h00, st);
    send_word(mx_msg, 1'b1, 32'h6357d2e7, -1, 8'h00, st);
    send_word(r_msg, 1'b0, 32'h0, -1, 8'h00, st);
    s_valid = 1'b0;
    drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 m_ready = 1'b1;

    // Reset in the middle of a codeword
    for (int i = 0; i < 100; i++) begin
      exp_t e;
      e.chk = 1'b1; e.last = 1'b0; e.data = 8'(8'ha5 ^ i);
      send_byte(e.data, e, st);
    end
    rstn = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_data", 32'(m_data), 32'd0);
    check("mid_rst_m_last", 32'(m_last), 32'd0);
    sb.delete();
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1 check("mid_rel_s_ready", 32'(s_ready), 32'd1);
    send_word(m1_msg, 1'b1, 32'h0f367840, -1, 8'h00, st);
    s_valid = 1'b0;
    drain();

`ifdef RS_ENC_ERRINJ_EN
    err_ena = 1'b1; err_idx = CNT_W'(10); err_pat = 8'h5a; skip_syn = 1'b1;
    send_word(z_msg, 1'b1, 32'h00000000, 10, 8'h5a, st);
    err_ena = 1'b0;
    s_valid = 1'b0;
    drain();
    skip_syn = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
